// File: rtl/monitor_output_collector.sv
// rtl/monitor_output_collector.sv - timestamps active monitor outputs, buffers records, emits framed 64-bit words
module monitor_output_collector #(
    parameter int NUM_OUT = 3,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_OUT*DATA_W-1:0] out_val,
    input  logic [NUM_OUT-1:0]        out_aktv,
    output logic [63:0]               m_data,
    output logic                      m_valid,
    output logic                      m_last,
    input  logic                      m_ready,
    output logic                      overflow,
    output logic [15:0]               drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    logic [31:0]               ts;
    logic [31:0]               f_ts   [DEPTH];
    logic [NUM_OUT-1:0]        f_mask [DEPTH];
    logic [NUM_OUT*DATA_W-1:0] f_val  [DEPTH];
    logic [PTR_W-1:0]          wr_ptr, rd_ptr;
    logic [PTR_W:0]            count;
    logic                      full, empty, capture, push, pop;

    state_t                    state, state_next;
    logic [31:0]               w_ts;
    logic [NUM_OUT-1:0]        w_mask;
    logic [NUM_OUT*DATA_W-1:0] w_val;
    logic [IDX_W-1:0]          cur, cur_next, low_bit, nxt_bit;
    logic                      has_next;
    logic [DATA_W-1:0]         cur_val;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign capture = en && (|out_aktv);
    assign push    = capture && !full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (en)
                ts <= ts + 32'd1;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + (PTR_W+1)'(1);
            else if (!push && pop)
                count <= count - (PTR_W+1)'(1);
            // fullness is judged before the edge, so a same-edge pop does not save the record
            if (capture && full) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_ts[wr_ptr]   <= ts;
            f_mask[wr_ptr] <= out_aktv;
            f_val[wr_ptr]  <= out_val;
        end
    end

    always_comb begin
        low_bit  = '0;
        nxt_bit  = '0;
        has_next = 1'b0;
        cur_val  = '0;
        for (int k = NUM_OUT - 1; k >= 0; k--) begin
            if (w_mask[k])
                low_bit = IDX_W'(k);
            if (w_mask[k] && (IDX_W'(k) > cur)) begin
                nxt_bit  = IDX_W'(k);
                has_next = 1'b1;
            end
            if (cur == IDX_W'(k))
                cur_val = w_val[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_next = state;
        cur_next   = cur;
        pop        = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = '0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                m_valid = 1'b1;
                m_data  = {8'hA5, 8'(w_mask), 16'h0000, w_ts};
                if (m_ready) begin
                    state_next = S_DATA;
                    cur_next   = low_bit;
                end
            end
            S_DATA: begin
                m_valid = 1'b1;
                m_last  = !has_next;
                m_data  = 64'($signed(cur_val));
                if (m_ready) begin
                    if (has_next) begin
                        cur_next = nxt_bit;
                    end else if (!empty) begin
                        pop        = 1'b1;
                        state_next = S_HDR;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cur    <= '0;
            w_ts   <= '0;
            w_mask <= '0;
            w_val  <= '0;
        end else begin
            state <= state_next;
            cur   <= cur_next;
            if (pop) begin
                w_ts   <= f_ts[rd_ptr];
                w_mask <= f_mask[rd_ptr];
                w_val  <= f_val[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_monitor_output_collector.sv
// tb/tb_monitor_output_collector.sv - scoreboard bench for monitor_output_collector
module tb_monitor_output_collector;
    localparam int NO = 3;
    localparam int DW = 32;
    localparam int DP = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en = 1'b0;
    logic [NO*DW-1:0] out_val = '0;
    logic [NO-1:0]  out_aktv = '0;
    logic [63:0]    m_data;
    logic           m_valid, m_last;
    logic           m_ready = 1'b0;
    logic           overflow;
    logic [15:0]    drop_cnt;

    int             n_cmp = 0;
    int             n_bad = 0;
    logic [31:0]    tb_ts = 0;
    logic [64:0]    exp_q[$];
    logic           stalled = 1'b0;
    logic [63:0]    prev_data = '0;
    logic           prev_last = 1'b0;

    monitor_output_collector #(.NUM_OUT(NO), .DATA_W(DW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .en(en), .out_val(out_val), .out_aktv(out_aktv),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (en && rst)
            tb_ts = tb_ts + 32'd1;
        #1;
    endtask

    task automatic push_record(input logic [2:0] mask, input logic [31:0] t,
                               input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
        logic [31:0] v [3];
        int hi;
        v  = '{v0, v1, v2};
        hi = -1;
        for (int k = 0; k < 3; k++)
            if (mask[k]) hi = k;
        exp_q.push_back({1'b0, 8'hA5, 5'b00000, mask, 16'h0000, t});
        for (int k = 0; k < 3; k++)
            if (mask[k]) exp_q.push_back({(k == hi), {32{v[k][31]}}, v[k]});
    endtask

    task automatic drive(input logic [2:0] mask, input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
        out_aktv = mask;
        out_val  = {v2, v1, v0};
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        step();
        step();
        check("idle_after_drain", {63'd0, m_valid}, 64'd0);
    endtask

    always @(negedge clk) begin
        logic [64:0] e;
        if (rst) begin
            if (stalled) begin
                check("hold_valid", {63'd0, m_valid}, 64'd1);
                check("hold_data", m_data, prev_data);
                check("hold_last", {63'd0, m_last}, {63'd0, prev_last});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %h expected none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", m_data, e[63:0]);
                    check("word_last", {63'd0, m_last}, {63'd0, e[64]});
                end
            end
        end
        stalled   = rst && m_valid && !m_ready;
        prev_data = m_data;
        prev_last = m_last;
    end

    initial begin
        // reset state
        #3;
        check("rst_valid", {63'd0, m_valid}, 64'd0);
        check("rst_last", {63'd0, m_last}, 64'd0);
        check("rst_data", m_data, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_drop", {48'd0, drop_cnt}, 64'd0);
        step();
        rst = 1'b1;
        en  = 1'b1;

        // single record at ts=1000 with 2-cycle header latency
        m_ready = 1'b1;
        for (int i = 0; i < 1000; i++) step();
        exp_q.push_back({1'b0, 64'hA5070000_000003E8});
        exp_q.push_back({1'b0, 64'd1});
        exp_q.push_back({1'b0, 64'd1});
        exp_q.push_back({1'b1, 64'd1});
        drive(3'b111, 1, 1, 1);
        step();
        drive(3'b000, 0, 0, 0);
        check("lat_not_yet", {63'd0, m_valid}, 64'd0);
        step();
        check("lat_header", {63'd0, m_valid}, 64'd1);
        drain();

        // sparse mask with sign extension
        exp_q.push_back({1'b0, 8'hA5, 8'h05, 16'h0000, tb_ts});
        exp_q.push_back({1'b0, 64'hFFFFFFFF_FFFFFFFB});
        exp_q.push_back({1'b1, 64'd7});
        drive(3'b101, -5, 9, 7);
        step();
        drive(3'b000, 0, 0, 0);
        drain();

        // backpressure
        push_record(3'b111, tb_ts, 3, -1, 5);
        drive(3'b111, 3, -1, 5);
        m_ready = 1'b0;
        step();
        drive(3'b000, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            m_ready = ~m_ready;
            step();
        end
        m_ready = 1'b1;
        drain();

        // overflow: 1 working + 8 buffered, 3 dropped
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 9) push_record(3'b001, tb_ts, 100 + i, 0, 0);
            drive(3'b001, 100 + i, 0, 0);
            step();
        end
        drive(3'b000, 0, 0, 0);
        step();
        check("ovf_drop_cnt", {48'd0, drop_cnt}, 64'd3);
        check("ovf_flag", {63'd0, overflow}, 64'd1);
        m_ready = 1'b1;
        drain();

        // enable low: nothing captured, ts held
        en = 1'b0;
        drive(3'b111, 1, 2, 3);
        for (int i = 0; i < 5; i++) begin
            step();
            check("en_low_idle", {63'd0, m_valid}, 64'd0);
        end
        en = 1'b1;
        push_record(3'b001, tb_ts, 42, 0, 0);
        drive(3'b001, 42, 0, 0);
        step();
        drive(3'b000, 0, 0, 0);
        drain();

        // timestamp wrap
        en = 1'b0;
        force dut.ts = 32'hFFFFFFFF;
        #1;
        release dut.ts;
        tb_ts = 32'hFFFFFFFF;
        en = 1'b1;
        push_record(3'b111, 32'hFFFFFFFF, 11, 12, 13);
        drive(3'b111, 11, 12, 13);
        step();
        push_record(3'b111, 32'h00000000, 11, 12, 13);
        step();
        drive(3'b000, 0, 0, 0);
        drain();

        // reset while stream 1 data word is pending
        m_ready = 1'b0;
        push_record(3'b111, tb_ts, 21, 22, 23);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        drive(3'b111, 21, 22, 23);
        step();
        drive(3'b000, 0, 0, 0);
        en = 1'b0;
        step();
        m_ready = 1'b1;
        step();
        step();
        m_ready = 1'b0;
        check("pre_rst_pending", {63'd0, m_valid}, 64'd1);
        check("pre_rst_data", m_data, 64'd22);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, m_valid}, 64'd0);
        check("rst_q_consumed", 64'(exp_q.size()), 64'd0);
        step();
        step();
        rst   = 1'b1;
        tb_ts = 0;
        check("post_rst_drop", {48'd0, drop_cnt}, 64'd0);
        check("post_rst_overflow", {63'd0, overflow}, 64'd0);
        en = 1'b1;
        push_record(3'b010, tb_ts, 0, 77, 0);
        drive(3'b010, 0, 77, 0);
        step();
        drive(3'b000, 0, 0, 0);
        m_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
